// File: rtl/alu_pkg.sv
// Shared constants, enums and the combinational ALU-control decode for the
// MIPS-32 ALU control block and its mult/div sequencer.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'h0;
    localparam logic [3:0] ALU_OR   = 4'h1;
    localparam logic [3:0] ALU_ADD  = 4'h2;
    localparam logic [3:0] ALU_SUB  = 4'h6;
    localparam logic [3:0] ALU_SLT  = 4'h7;
    localparam logic [3:0] ALU_NOR  = 4'h8;
    localparam logic [3:0] ALU_XOR  = 4'h9;
    localparam logic [3:0] ALU_SLL  = 4'hA;
    localparam logic [3:0] ALU_SRL  = 4'hB;
    localparam logic [3:0] ALU_SRA  = 4'hC;
    localparam logic [3:0] ALU_SLTU = 4'hD;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [5:0] FUNCT_SLL   = 6'h00;
    localparam logic [5:0] FUNCT_SRL   = 6'h02;
    localparam logic [5:0] FUNCT_SRA   = 6'h03;
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
    localparam logic [5:0] FUNCT_ADD   = 6'h20;
    localparam logic [5:0] FUNCT_ADDU  = 6'h21;
    localparam logic [5:0] FUNCT_SUB   = 6'h22;
    localparam logic [5:0] FUNCT_SUBU  = 6'h23;
    localparam logic [5:0] FUNCT_AND   = 6'h24;
    localparam logic [5:0] FUNCT_OR    = 6'h25;
    localparam logic [5:0] FUNCT_XOR   = 6'h26;
    localparam logic [5:0] FUNCT_NOR   = 6'h27;
    localparam logic [5:0] FUNCT_SLT   = 6'h2A;
    localparam logic [5:0] FUNCT_SLTU  = 6'h2B;

    // Encoding matches func[1:0] of the mult/div instructions.
    typedef enum logic [1:0] {
        MULT  = 2'b00,
        MULTU = 2'b01,
        DIV   = 2'b10,
        DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } md_state_e;

    function automatic logic [3:0] decodeAluCtr(input logic [1:0] aluOp, input logic [5:0] func);
        logic [3:0] ctr;
        ctr = ALU_ADD;
        case (aluOp)
            ALUOP_SUB: ctr = ALU_SUB;
            ALUOP_OR:  ctr = ALU_OR;
            ALUOP_RTYPE: begin
                case (func)
                    FUNCT_ADD, FUNCT_ADDU: ctr = ALU_ADD;
                    FUNCT_SUB, FUNCT_SUBU: ctr = ALU_SUB;
                    FUNCT_AND:             ctr = ALU_AND;
                    FUNCT_OR:              ctr = ALU_OR;
                    FUNCT_XOR:             ctr = ALU_XOR;
                    FUNCT_NOR:             ctr = ALU_NOR;
                    FUNCT_SLT:             ctr = ALU_SLT;
                    FUNCT_SLTU:            ctr = ALU_SLTU;
                    FUNCT_SLL:             ctr = ALU_SLL;
                    FUNCT_SRL:             ctr = ALU_SRL;
                    FUNCT_SRA:             ctr = ALU_SRA;
                    default:               ctr = ALU_ADD;
                endcase
            end
            default: ctr = ALU_ADD;
        endcase
        return ctr;
    endfunction

endpackage

// File: rtl/md_sequencer.sv
// Sequences the iterative mult/div unit: launch pulse, cycle countdown,
// one-cycle HI/LO write strobe and the ID-stage stall for HI/LO hazards.
module md_sequencer
    import alu_pkg::*;
#(
    parameter int MUL_CYCLES = 32,
    parameter int DIV_CYCLES = 32
) (
    input  logic       i_clk,
    input  logic       i_resetN,
    input  logic       i_flush,
    input  logic       i_mdReq,
    input  md_op_e     i_mdOpSel,
    input  logic       i_hiloAccess,
    input  logic       i_hiloRead,
    output logic       o_mdStart,
    output logic [1:0] o_mdOp,
    output logic       o_mdBusy,
    output logic       o_hiloWe,
    output logic       o_stall
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    md_state_e        r_state;
    md_state_e        w_nextState;
    logic [CNT_W-1:0] r_count;
    md_op_e           r_mdOp;
    logic             w_stall;
    logic             w_accept;

    // A squashed instruction must never launch, so flush outranks acceptance.
    assign w_stall  = ((r_state == RUN) && (i_mdReq || i_hiloAccess)) ||
                      ((r_state == DONE) && i_hiloRead);
    assign w_accept = i_mdReq && !w_stall && !i_flush;

    always_ff @(posedge i_clk) begin
        if (!i_resetN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_resetN) begin
            r_count <= '0;
            r_mdOp  <= MULT;
        end else if (w_accept) begin
            r_count <= (i_mdOpSel inside {DIV, DIVU}) ? DIV_LOAD : MUL_LOAD;
            r_mdOp  <= i_mdOpSel;
        end else if ((r_state == RUN) && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: if (w_accept) w_nextState = RUN;
            RUN: begin
                if (i_flush) begin
                    w_nextState = IDLE;
                end else if (r_count == '0) begin
                    w_nextState = DONE;
                end
            end
            DONE:    w_nextState = w_accept ? RUN : IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Outputs are held low while reset is asserted so an abandoned op writes nothing.
    always_comb begin
        o_mdStart = i_resetN && w_accept;
        o_mdBusy  = i_resetN && (r_state == RUN);
        o_hiloWe  = i_resetN && (r_state == DONE) && !i_flush;
        o_stall   = i_resetN && w_stall;
        o_mdOp    = r_mdOp;
    end

endmodule

// File: rtl/alu_control_mc.sv
// MIPS-32 ALU control: combinational alu_op/func decode plus the mult/div
// sequencer that drives the HI/LO unit and the hazard unit.
module alu_control_mc
    import alu_pkg::*;
#(
    parameter int CTR_W      = 4,
    parameter int MUL_CYCLES = 32,
    parameter int DIV_CYCLES = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             valid_in,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       func,
    input  logic             flush,
    output logic [CTR_W-1:0] alu_ctr,
    output logic             md_start,
    output logic [1:0]       md_op,
    output logic             md_busy,
    output logic             hilo_we,
    output logic             stall
);

    logic [3:0] w_ctrCode;
    logic       w_isRtype;
    logic       w_mdReq;
    logic       w_hiloAccess;
    logic       w_hiloRead;
    md_op_e     w_mdOpSel;

    assign w_ctrCode = decodeAluCtr(alu_op, func);
    assign alu_ctr   = CTR_W'(w_ctrCode);

    // Sequencing only ever looks at valid R-type instructions.
    assign w_isRtype    = valid_in && (alu_op == ALUOP_RTYPE);
    assign w_mdReq      = w_isRtype &&
                          (func inside {FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU});
    assign w_hiloAccess = w_isRtype &&
                          (func inside {FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO});
    assign w_hiloRead   = w_isRtype && (func inside {FUNCT_MFHI, FUNCT_MFLO});
    assign w_mdOpSel    = md_op_e'(func[1:0]);

    md_sequencer #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_mdSequencer (
        .i_clk        (clk),
        .i_resetN     (reset_n),
        .i_flush      (flush),
        .i_mdReq      (w_mdReq),
        .i_mdOpSel    (w_mdOpSel),
        .i_hiloAccess (w_hiloAccess),
        .i_hiloRead   (w_hiloRead),
        .o_mdStart    (md_start),
        .o_mdOp       (md_op),
        .o_mdBusy     (md_busy),
        .o_hiloWe     (hilo_we),
        .o_stall      (stall)
    );

endmodule

// File: tb/tb_alu_control_mc.sv
// Self-checking bench for alu_control_mc: decode table sweep, directed
// mult/div corner sequences and a randomized run against a reference model.
module tb_alu_control_mc;

    localparam int CTR_W   = 4;
    localparam int MUL_CYC = 4;
    localparam int DIV_CYC = 6;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             valid_in;
    logic [1:0]       alu_op;
    logic [5:0]       func;
    logic             flush;
    logic [CTR_W-1:0] alu_ctr;
    logic             md_start;
    logic [1:0]       md_op;
    logic             md_busy;
    logic             hilo_we;
    logic             stall;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0] op;
        logic [5:0] fn;
        logic [3:0] ctr;
    } decodeVec_t;

    decodeVec_t decodeTable[$];

    // Reference model state: busy cycles still owed, and whether this cycle is the write cycle.
    int         mBusyLeft;
    bit         mWriteNow;
    logic [1:0] mOp;

    always #5 clk = ~clk;

    alu_control_mc #(
        .CTR_W      (CTR_W),
        .MUL_CYCLES (MUL_CYC),
        .DIV_CYCLES (DIV_CYC)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .valid_in (valid_in),
        .alu_op   (alu_op),
        .func     (func),
        .flush    (flush),
        .alu_ctr  (alu_ctr),
        .md_start (md_start),
        .md_op    (md_op),
        .md_busy  (md_busy),
        .hilo_we  (hilo_we),
        .stall    (stall)
    );

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic addVec(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] ctr);
        decodeVec_t v;
        v.op  = op;
        v.fn  = fn;
        v.ctr = ctr;
        decodeTable.push_back(v);
    endtask

    // Expected alu_ctr: fixed codes for non-R-type, else table lookup with add as fallback.
    function automatic logic [3:0] refCtr(input logic [1:0] op, input logic [5:0] fn);
        logic [3:0] r;
        r = 4'h2;
        if (op == 2'b01) begin
            r = 4'h6;
        end else if (op == 2'b11) begin
            r = 4'h1;
        end else if (op == 2'b10) begin
            foreach (decodeTable[i]) begin
                if (decodeTable[i].op == 2'b10 && decodeTable[i].fn == fn) r = decodeTable[i].ctr;
            end
        end
        return r;
    endfunction

    // Drive one cycle of inputs at the falling edge and let them settle before checks.
    task automatic applyStimulus(input logic rn, input logic v, input logic [1:0] op,
                                 input logic [5:0] fn, input logic fl);
        @(negedge clk);
        reset_n  = rn;
        valid_in = v;
        alu_op   = op;
        func     = fn;
        flush    = fl;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic expectSeq(input string tag, input logic eStart, input logic eBusy,
                             input logic eWe, input logic eStall, input int eOp);
        checkOutput({tag, " md_start"}, 32'(md_start), 32'(eStart));
        checkOutput({tag, " md_busy"},  32'(md_busy),  32'(eBusy));
        checkOutput({tag, " hilo_we"},  32'(hilo_we),  32'(eWe));
        checkOutput({tag, " stall"},    32'(stall),    32'(eStall));
        if (eOp >= 0) checkOutput({tag, " md_op"}, 32'(md_op), eOp);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b1, 1'b0, 2'b00, 6'h00, 1'b0);
    endtask

    initial begin
        reset_n  = 1'b0;
        valid_in = 1'b0;
        alu_op   = 2'b00;
        func     = 6'h00;
        flush    = 1'b0;

        addVec(2'b10, 6'h20, 4'h2); addVec(2'b10, 6'h21, 4'h2);
        addVec(2'b10, 6'h22, 4'h6); addVec(2'b10, 6'h23, 4'h6);
        addVec(2'b10, 6'h24, 4'h0); addVec(2'b10, 6'h25, 4'h1);
        addVec(2'b10, 6'h26, 4'h9); addVec(2'b10, 6'h27, 4'h8);
        addVec(2'b10, 6'h2A, 4'h7); addVec(2'b10, 6'h2B, 4'hD);
        addVec(2'b10, 6'h00, 4'hA); addVec(2'b10, 6'h02, 4'hB);
        addVec(2'b10, 6'h03, 4'hC); addVec(2'b10, 6'h18, 4'h2);
        addVec(2'b10, 6'h1B, 4'h2); addVec(2'b10, 6'h10, 4'h2);
        addVec(2'b10, 6'h01, 4'h2); addVec(2'b10, 6'h3F, 4'h2);
        addVec(2'b00, 6'h24, 4'h2); addVec(2'b01, 6'h25, 4'h6);
        addVec(2'b11, 6'h2B, 4'h1);

        // Reset: outputs read zero while reset is low, even with an MD op presented.
        applyStimulus(1'b0, 1'b1, 2'b10, 6'h19, 1'b0);
        expectSeq("reset held", 1'b0, 1'b0, 1'b0, 1'b0, 0);
        idleCycle();
        expectSeq("after reset", 1'b0, 1'b0, 1'b0, 1'b0, 0);

        // Decode table, then the full alu_op x func sweep; valid_in=0 keeps the sequencer idle.
        foreach (decodeTable[i]) begin
            applyStimulus(1'b1, 1'b0, decodeTable[i].op, decodeTable[i].fn, 1'b0);
            checkOutput($sformatf("decode table op=%0b fn=%02h", decodeTable[i].op, decodeTable[i].fn),
                        32'(alu_ctr), 32'(decodeTable[i].ctr));
        end
        for (int k = 0; k < 256; k++) begin
            applyStimulus(1'b1, 1'b0, 2'(k >> 6), 6'(k), 1'b0);
            checkOutput($sformatf("decode sweep op=%0b fn=%02h", alu_op, func),
                        32'(alu_ctr), 32'(refCtr(alu_op, func)));
        end
        checkOutput("sweep left sequencer idle", 32'(md_busy), 32'(0));

        // valid_in=0 MD op must not launch.
        applyStimulus(1'b1, 1'b0, 2'b10, 6'h18, 1'b0);
        expectSeq("invalid md", 1'b0, 1'b0, 1'b0, 1'b0, 0);
        idleCycle();
        expectSeq("invalid md+1", 1'b0, 1'b0, 1'b0, 1'b0, 0);

        // MULT: start at cycle 0, busy 1..MUL_CYC, write at MUL_CYC+1.
        applyStimulus(1'b1, 1'b1, 2'b10, 6'h18, 1'b0);
        expectSeq("mult c0", 1'b1, 1'b0, 1'b0, 1'b0, 0);
        checkOutput("mult c0 alu_ctr", 32'(alu_ctr), 32'(2));
        for (int c = 1; c <= MUL_CYC + 2; c++) begin
            idleCycle();
            expectSeq($sformatf("mult c%0d", c), 1'b0, c <= MUL_CYC, c == MUL_CYC + 1, 1'b0, 0);
        end

        // DIV with mflo waiting from cycle 2: stalled through the write cycle.
        applyStimulus(1'b1, 1'b1, 2'b10, 6'h1A, 1'b0);
        expectSeq("div c0", 1'b1, 1'b0, 1'b0, 1'b0, -1);
        idleCycle();
        expectSeq("div c1", 1'b0, 1'b1, 1'b0, 1'b0, 2);
        for (int c = 2; c <= DIV_CYC + 2; c++) begin
            applyStimulus(1'b1, 1'b1, 2'b10, 6'h12, 1'b0);
            expectSeq($sformatf("div mflo c%0d", c), 1'b0, c <= DIV_CYC, c == DIV_CYC + 1,
                      c <= DIV_CYC + 1, 2);
        end

        // Back-to-back: DIVU presented in the MULT write cycle.
        applyStimulus(1'b1, 1'b1, 2'b10, 6'h18, 1'b0);
        expectSeq("b2b c0", 1'b1, 1'b0, 1'b0, 1'b0, -1);
        for (int c = 1; c <= MUL_CYC; c++) begin
            idleCycle();
            expectSeq($sformatf("b2b mult c%0d", c), 1'b0, 1'b1, 1'b0, 1'b0, 0);
        end
        applyStimulus(1'b1, 1'b1, 2'b10, 6'h1B, 1'b0);
        expectSeq("b2b done+start", 1'b1, 1'b0, 1'b1, 1'b0, 0);
        for (int c = 1; c <= DIV_CYC + 2; c++) begin
            idleCycle();
            expectSeq($sformatf("b2b divu c%0d", c), 1'b0, c <= DIV_CYC, c == DIV_CYC + 1, 1'b0, 3);
        end

        // Flush in RUN at cycle 2: idle next edge, no write ever, stall drops.
        applyStimulus(1'b1, 1'b1, 2'b10, 6'h1A, 1'b0);
        expectSeq("flush run c0", 1'b1, 1'b0, 1'b0, 1'b0, -1);
        idleCycle();
        expectSeq("flush run c1", 1'b0, 1'b1, 1'b0, 1'b0, 2);
        applyStimulus(1'b1, 1'b1, 2'b10, 6'h12, 1'b1);
        expectSeq("flush run c2", 1'b0, 1'b1, 1'b0, 1'b1, 2);
        for (int c = 3; c <= DIV_CYC + 4; c++) begin
            applyStimulus(1'b1, c == 3, 2'b10, 6'h12, 1'b0);
            expectSeq($sformatf("flush run c%0d", c), 1'b0, 1'b0, 1'b0, 1'b0, 2);
        end

        // Flush in DONE with a DIVU presented: no write, no start.
        applyStimulus(1'b1, 1'b1, 2'b10, 6'h18, 1'b0);
        expectSeq("flush done c0", 1'b1, 1'b0, 1'b0, 1'b0, -1);
        for (int c = 1; c <= MUL_CYC; c++) idleCycle();
        applyStimulus(1'b1, 1'b1, 2'b10, 6'h1B, 1'b1);
        expectSeq("flush done", 1'b0, 1'b0, 1'b0, 1'b0, 0);
        idleCycle();
        expectSeq("flush done+1", 1'b0, 1'b0, 1'b0, 1'b0, 0);

        // Reset mid-RUN: operation abandoned, md_op back to 00, no write.
        applyStimulus(1'b1, 1'b1, 2'b10, 6'h1B, 1'b0);
        expectSeq("rst run c0", 1'b1, 1'b0, 1'b0, 1'b0, -1);
        idleCycle();
        expectSeq("rst run c1", 1'b0, 1'b1, 1'b0, 1'b0, 3);
        applyStimulus(1'b0, 1'b0, 2'b00, 6'h00, 1'b0);
        expectSeq("rst run c2", 1'b0, 1'b0, 1'b0, 1'b0, -1);
        for (int c = 3; c <= DIV_CYC + 3; c++) begin
            idleCycle();
            expectSeq($sformatf("rst run c%0d", c), 1'b0, 1'b0, 1'b0, 1'b0, 0);
        end

        // Independent ALU ops during RUN neither stall nor disturb the count.
        applyStimulus(1'b1, 1'b1, 2'b10, 6'h19, 1'b0);
        expectSeq("indep c0", 1'b1, 1'b0, 1'b0, 1'b0, -1);
        applyStimulus(1'b1, 1'b1, 2'b00, 6'h12, 1'b0);
        expectSeq("indep c1", 1'b0, 1'b1, 1'b0, 1'b0, 1);
        checkOutput("indep c1 alu_ctr", 32'(alu_ctr), 32'(2));
        applyStimulus(1'b1, 1'b1, 2'b10, 6'h20, 1'b0);
        expectSeq("indep c2", 1'b0, 1'b1, 1'b0, 1'b0, 1);
        checkOutput("indep c2 alu_ctr", 32'(alu_ctr), 32'(2));
        applyStimulus(1'b1, 1'b1, 2'b10, 6'h22, 1'b0);
        expectSeq("indep c3", 1'b0, 1'b1, 1'b0, 1'b0, 1);
        checkOutput("indep c3 alu_ctr", 32'(alu_ctr), 32'(6));
        for (int c = 4; c <= MUL_CYC + 2; c++) begin
            idleCycle();
            expectSeq($sformatf("indep c%0d", c), 1'b0, c <= MUL_CYC, c == MUL_CYC + 1, 1'b0, 1);
        end

        // Randomized run against the reference model, starting from reset.
        applyStimulus(1'b0, 1'b0, 2'b00, 6'h00, 1'b0);
        mBusyLeft = 0;
        mWriteNow = 1'b0;
        mOp       = 2'b00;
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic       rn, v, fl;
            logic [1:0] op;
            logic [5:0] fn;
            logic       isR, isMd, isHilo, isRead, eBusy, eStall, eStart, eWe;
            int         sel;
            rn  = ($urandom_range(0, 99) >= 2);
            v   = ($urandom_range(0, 9) < 8);
            op  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b10;
            sel = int'($urandom_range(0, 9));
            if (sel < 4)      fn = 6'h18 + 6'($urandom_range(0, 3));
            else if (sel < 7) fn = 6'h10 + 6'($urandom_range(0, 3));
            else              fn = 6'($urandom_range(0, 63));
            fl  = ($urandom_range(0, 29) == 0);
            applyStimulus(rn, v, op, fn, fl);

            isR    = v && (op == 2'b10);
            isMd   = isR && (fn >= 6'h18) && (fn <= 6'h1B);
            isHilo = isR && (fn >= 6'h10) && (fn <= 6'h13);
            isRead = isR && (fn == 6'h10 || fn == 6'h12);
            eBusy  = (mBusyLeft > 0);
            eStall = (eBusy && (isMd || isHilo)) || (mWriteNow && isRead);
            eStart = isMd && !eStall && !fl && !eBusy;
            eWe    = mWriteNow && !fl;
            expectSeq($sformatf("rand %0d", cyc), rn && eStart, rn && eBusy, rn && eWe,
                      rn && eStall, int'(mOp));
            checkOutput($sformatf("rand %0d alu_ctr", cyc), 32'(alu_ctr), 32'(refCtr(op, fn)));

            if (!rn) begin
                mBusyLeft = 0;
                mWriteNow = 1'b0;
                mOp       = 2'b00;
            end else if (fl) begin
                mBusyLeft = 0;
                mWriteNow = 1'b0;
            end else if (eStart) begin
                mBusyLeft = (fn >= 6'h1A) ? DIV_CYC : MUL_CYC;
                mWriteNow = 1'b0;
                mOp       = fn[1:0];
            end else if (eBusy) begin
                mBusyLeft = mBusyLeft - 1;
                mWriteNow = (mBusyLeft == 0);
            end else begin
                mWriteNow = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
